// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin front end that shares one lookup ROM among
// NUM_REQ requesters. The ROM has a one-hot address and a 1-cycle registered
// read, and its output is 0 when it is not enabled.
// Each accepted request runs IDLE -> ISSUE -> CAPTURE -> RESP. The response
// is held until the owning requester accepts it.
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_req_valid     per-requester read request
//   i_req_idx       packed binary indices, requester k at [k*IDX_W +: IDX_W]
//   o_req_ready     one-hot, combinational: the request of requester k is
//                   accepted this cycle
//   o_rsp_valid     one-hot response strobe for the owning requester
//   o_rsp_data      shared response data (registered)
//   i_rsp_ready     per-requester response acceptance
//   o_rom_addr      one-hot ROM address
//   o_rom_en        ROM read enable
//   i_rom_data      registered ROM output
//   o_busy          high in every state except IDLE
module rom_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ROM_DEPTH = 8,
  parameter int unsigned DATA_W    = 8,
  localparam int unsigned IDX_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] i_req_idx,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  input  logic [NUM_REQ-1:0]       i_rsp_ready,
  output logic [ROM_DEPTH-1:0]     o_rom_addr,
  output logic                     o_rom_en,
  input  logic [DATA_W-1:0]        i_rom_data,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ROM_DEPTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]   grant_c;
  logic                 found_c;
  logic [PTR_W-1:0]     win_c;
  logic [IDX_W-1:0]     win_idx_c;
  int unsigned          cand_c;

  // State register; reset returns to IDLE with req 0 first in line
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Round-robin search plus next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    grant_c    = '0;
    found_c    = 1'b0;
    win_c      = '0;
    win_idx_c  = '0;
    cand_c     = 0;

    // Search starts just after the last winner, so the last winner is tried last
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_c = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!found_c && i_req_valid[cand_c]) begin
        found_c   = 1'b1;
        win_c     = PTR_W'(cand_c);
        win_idx_c = i_req_idx[cand_c*IDX_W +: IDX_W];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found_c) begin
          grant_c  = NUM_REQ'(1) << win_c;
          owner_d  = win_c;
          rr_ptr_d = win_c;
          // An index beyond the ROM depth shifts out to an all-zero address
          addr_d   = ROM_DEPTH'(1) << win_idx_c;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        rsp_data_d = i_rom_data;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // No acceptance is reported while reset is asserted
  assign o_req_ready = i_rst_n ? grant_c : '0;
  assign o_rom_en    = (state_q == S_ISSUE);
  assign o_rom_addr  = (state_q == S_ISSUE) ? addr_q : '0;
  assign o_rsp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
